gpio_regs: RTL and testbench

Parametrised GPIO register bank on the `axi_registers` read/write strobe interface, and the successor to the fixed four-register switch/button/LED map. It provides `NIN` synchronised and debounced inputs, `NOUT` outputs with write, set and clear access, and sticky rising/falling-edge status with write-1-to-clear. A maskable, registered interrupt output feeds the PS7 fabric interrupt line.

---
 rtl/gpio_regs_pkg.sv | 19 +
 rtl/gpio_debounce.sv | 59 +++++
 rtl/gpio_regs.sv | 118 +++++++++++
 tb/tb_gpio_regs.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_regs_pkg.sv
// Shared definitions for the GPIO register bank: register word indices
// and the read-only identification constant.
package gpio_regs_pkg;

    typedef enum logic [2:0] {
        GPIO_OUT     = 3'd0,
        GPIO_OUT_SET = 3'd1,
        GPIO_OUT_CLR = 3'd2,
        GPIO_IN      = 3'd3,
        GPIO_RISE    = 3'd4,
        GPIO_FALL    = 3'd5,
        GPIO_IRQ_EN  = 3'd6,
        GPIO_ID      = 3'd7
    } gpio_reg_t;

    // The enum already owns the name GPIO_ID, so the ID word gets a suffix.
    localparam logic [31:0] GPIO_ID_VALUE = 32'h4750_4901;

endpackage

// File: rtl/gpio_debounce.sv
// Single-bit input conditioner: synchroniser chain followed by a
// saturating debounce counter. A new level is accepted only after the
// synchronised input has differed from the stable value for 2^DB_BITS
// consecutive cycles; the acceptance cycle emits a one-cycle edge pulse.
module gpio_debounce
    import gpio_regs_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DB_BITS     = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic stable,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DB_BITS-1:0]     cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   sync;

    assign sync   = sync_q[SYNC_STAGES-1];
    assign stable = stable_q;

    // Next-state: shift the synchroniser, count while the input disagrees,
    // and commit the new level once the counter has saturated.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], pin};
        cnt_d      = '0;
        stable_d   = stable_q;
        rise_pulse = 1'b0;
        fall_pulse = 1'b0;
        if (sync != stable_q) begin
            if (&cnt_q) begin
                stable_d   = sync;
                rise_pulse = sync;
                fall_pulse = ~sync;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

endmodule

// File: rtl/gpio_regs.sv
// Parametrised GPIO register bank on the axi_registers strobe interface:
// debounced inputs, write/set/clear outputs, sticky W1C edge status and a
// maskable registered interrupt.
module gpio_regs
    import gpio_regs_pkg::*;
#(
    parameter int unsigned      NIN         = 8,
    parameter int unsigned      NOUT        = 4,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      DB_BITS     = 16,
    parameter logic [NOUT-1:0]  OUT_RESET   = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      i_rreg,
    input  logic [2:0]      i_wreg,
    input  logic [31:0]     i_wdata,
    input  logic            i_wr,
    input  logic            i_rd,
    output logic [31:0]     o_rdata,
    input  logic [NIN-1:0]  i_pins,
    output logic [NOUT-1:0] o_pins,
    output logic            o_irq
);

    logic [NOUT-1:0] out_q, out_d;
    logic [NIN-1:0]  rise_q, rise_d;
    logic [NIN-1:0]  fall_q, fall_d;
    logic [NIN-1:0]  irq_en_q, irq_en_d;
    logic            irq_q, irq_d;
    logic [NIN-1:0]  in_stable;
    logic [NIN-1:0]  rise_pulse;
    logic [NIN-1:0]  fall_pulse;
    logic [NIN-1:0]  rise_clr;
    logic [NIN-1:0]  fall_clr;
    gpio_reg_t       wr_sel;
    gpio_reg_t       rd_sel;

    // Reads have no side effects, so the read strobe carries no information.
    logic unused_rd;
    assign unused_rd = i_rd;

    assign wr_sel = gpio_reg_t'(i_wreg);
    assign rd_sel = gpio_reg_t'(i_rreg);
    assign o_pins = out_q;
    assign o_irq  = irq_q;

    for (genvar g = 0; g < NIN; g++) begin : g_in
        gpio_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_BITS     (DB_BITS)
        ) u_db (
            .clk        (clk),
            .reset      (reset),
            .pin        (i_pins[g]),
            .stable     (in_stable[g]),
            .rise_pulse (rise_pulse[g]),
            .fall_pulse (fall_pulse[g])
        );
    end

    // Register writes, sticky status update and interrupt evaluation.
    always_comb begin
        out_d    = out_q;
        irq_en_d = irq_en_q;
        rise_clr = '0;
        fall_clr = '0;
        if (i_wr) begin
            case (wr_sel)
                GPIO_OUT:     out_d    = i_wdata[NOUT-1:0];
                GPIO_OUT_SET: out_d    = out_q | i_wdata[NOUT-1:0];
                GPIO_OUT_CLR: out_d    = out_q & ~i_wdata[NOUT-1:0];
                GPIO_RISE:    rise_clr = i_wdata[NIN-1:0];
                GPIO_FALL:    fall_clr = i_wdata[NIN-1:0];
                GPIO_IRQ_EN:  irq_en_d = i_wdata[NIN-1:0];
                default:      ;
            endcase
        end
        // A new edge in the same cycle as a W1C keeps the bit set.
        rise_d = (rise_q & ~rise_clr) | rise_pulse;
        fall_d = (fall_q & ~fall_clr) | fall_pulse;
        irq_d  = |((rise_q | fall_q) & irq_en_q);
    end

    // Register file and interrupt flop with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q    <= OUT_RESET;
            rise_q   <= '0;
            fall_q   <= '0;
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            out_q    <= out_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    // Combinational read mux; unimplemented upper bits read as zero.
    always_comb begin
        o_rdata = '0;
        case (rd_sel)
            GPIO_OUT,
            GPIO_OUT_SET,
            GPIO_OUT_CLR: o_rdata = 32'(out_q);
            GPIO_IN:      o_rdata = 32'(in_stable);
            GPIO_RISE:    o_rdata = 32'(rise_q);
            GPIO_FALL:    o_rdata = 32'(fall_q);
            GPIO_IRQ_EN:  o_rdata = 32'(irq_en_q);
            GPIO_ID:      o_rdata = GPIO_ID_VALUE;
            default:      o_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_gpio_regs.sv
// Scoreboard bench for gpio_regs with a short debounce window.
module tb_gpio_regs;

    localparam int unsigned NIN  = 8;
    localparam int unsigned NOUT = 4;
    localparam int unsigned SS   = 2;
    localparam int unsigned DB   = 4;
    localparam logic [NOUT-1:0] OUT_RST = 4'h9;
    localparam int DB_T = SS + (1 << DB);
    localparam logic [31:0] ID_WORD = 32'h4750_4901;

    logic            clk;
    logic            reset;
    logic [2:0]      i_rreg;
    logic [2:0]      i_wreg;
    logic [31:0]     i_wdata;
    logic            i_wr;
    logic            i_rd;
    logic [31:0]     o_rdata;
    logic [NIN-1:0]  i_pins;
    logic [NOUT-1:0] o_pins;
    logic            o_irq;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    gpio_regs #(
        .NIN         (NIN),
        .NOUT        (NOUT),
        .SYNC_STAGES (SS),
        .DB_BITS     (DB),
        .OUT_RESET   (OUT_RST)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_rreg  (i_rreg),
        .i_wreg  (i_wreg),
        .i_wdata (i_wdata),
        .i_wr    (i_wr),
        .i_rd    (i_rd),
        .o_rdata (o_rdata),
        .i_pins  (i_pins),
        .o_pins  (o_pins),
        .o_irq   (o_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input int idx, output logic [31:0] d);
        i_rreg = idx[2:0];
        i_rd   = 1'b1;
        #1;
        d    = o_rdata;
        i_rd = 1'b0;
    endtask

    task automatic wr(input int idx, input logic [31:0] d);
        i_wreg  = idx[2:0];
        i_wdata = d;
        i_wr    = 1'b1;
        step(1);
        i_wr    = 1'b0;
    endtask

    task automatic push(input string n, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        logic [31:0] obs;
        exp_t e;
        reset = 1'b1;
        step(2);
        push("rst_out", 32'(OUT_RST));
        push("rst_out_set", 32'(OUT_RST));
        push("rst_out_clr", 32'(OUT_RST));
        push("rst_in", 32'h0);
        push("rst_rise", 32'h0);
        push("rst_fall", 32'h0);
        push("rst_irq_en", 32'h0);
        push("rst_id", ID_WORD);
        for (int i = 0; i < 8; i++) begin
            rd(i, obs);
            e = sb.pop_front();
            checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
            end
        end
        push("rst_pins", 32'(OUT_RST));
        push("rst_o_irq", 32'h0);
        e = sb.pop_front();
        checks++;
        if (32'(o_pins) !== e.val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, o_pins, e.val);
        end
        e = sb.pop_front();
        checks++;
        if (32'(o_irq) !== e.val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, o_irq, e.val);
        end
        step(1);
        reset = 1'b0;
    endtask

    task automatic test_debounce();
        logic [31:0] obs;
        exp_t e;
        step(1);
        i_pins[0] = 1'b1;
        push("db_in_early", 32'h0);
        step(DB_T - 1);
        rd(3, obs);
        e = sb.pop_front();
        checks++;
        if (obs !== e.val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
        end
        push("db_in_edge", 32'h1);
        push("db_rise_edge", 32'h1);
        push("db_fall_edge", 32'h0);
        step(1);
        for (int i = 3; i < 6; i++) begin
            rd(i, obs);
            e = sb.pop_front();
            checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
            end
        end
        // 10-cycle glitch on bit 1 must be filtered out.
        i_pins[1] = 1'b1;
        step(10);
        i_pins[1] = 1'b0;
        push("glitch_in", 32'h1);
        push("glitch_rise", 32'h1);
        push("glitch_fall", 32'h0);
        step(DB_T + 4);
        for (int i = 3; i < 6; i++) begin
            rd(i, obs);
            e = sb.pop_front();
            checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
            end
        end
    endtask

    task automatic test_out();
        logic [31:0] obs;
        exp_t e;
        logic [31:0] wv [4] = '{32'h5, 32'h2, 32'h4, 32'hFFFF_FFF0};
        int          wi [4] = '{0, 1, 2, 0};
        logic [31:0] ev [4] = '{32'h5, 32'h7, 32'h3, 32'h0};
        for (int i = 0; i < 4; i++) begin
            push($sformatf("out_pins_%0d", i), ev[i]);
            push($sformatf("out_read_%0d", i), ev[i]);
            wr(wi[i], wv[i]);
            e = sb.pop_front();
            checks++;
            if (32'(o_pins) !== e.val) begin
                errors++;
                $display("FAIL %s: got %h, expected %h", e.name, o_pins, e.val);
            end
            rd(wi[i], obs);
            e = sb.pop_front();
            checks++;
            if (obs !== e.val) begin
                errors++;
                $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
            end
        end
    endtask

    task automatic test_irq();
        logic [31:0] obs;
        exp_t e;
        wr(4, 32'hFF);
        wr(6, 32'h10);
        i_pins[4] = 1'b1;
        push("irq_rise4", 32'h10);
        push("irq_low_at_set", 32'h0);
        step(DB_T);
        rd(4, obs);
        e = sb.pop_front();
        checks++;
        if (obs !== e.val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
        end
        e = sb.pop_front();
        checks++;
        if (32'(o_irq) !== e.val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, o_irq, e.val);
        end
        push("irq_high", 32'h1);
        step(1);
        e = sb.pop_front();
        checks++;
        if (32'(o_irq) !== e.val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, o_irq, e.val);
        end
        // W1C the only enabled status bit.
        push("w1c_rise_read", 32'h0);
        push("w1c_irq_hold", 32'h1);
        push("w1c_irq_drop", 32'h0);
        wr(4, 32'h10);
        rd(4, obs);
        e = sb.pop_front();
        checks++;
        if (obs !== e.val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
        end
        e = sb.pop_front();
        checks++;
        if (32'(o_irq) !== e.val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, o_irq, e.val);
        end
        step(1);
        e = sb.pop_front();
        checks++;
        if (32'(o_irq) !== e.val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, o_irq, e.val);
        end
        // Falling edge raises irq; clearing the enable drops it.
        i_pins[4] = 1'b0;
        push("fall_irq_high", 32'h1);
        push("fall4_read", 32'h10);
        push("en_clr_irq_hold", 32'h1);
        push("en_clr_irq_drop", 32'h0);
        step(DB_T + 1);
        e = sb.pop_front();
        checks++;
        if (32'(o_irq) !== e.val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, o_irq, e.val);
        end
        rd(5, obs);
        e = sb.pop_front();
        checks++;
        if (obs !== e.val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
        end
        wr(6, 32'h0);
        e = sb.pop_front();
        checks++;
        if (32'(o_irq) !== e.val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, o_irq, e.val);
        end
        step(1);
        e = sb.pop_front();
        checks++;
        if (32'(o_irq) !== e.val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, o_irq, e.val);
        end
        // Read-only registers and width clipping.
        wr(3, 32'hFFFF_FFFF);
        wr(7, 32'hFFFF_FFFF);
        wr(6, 32'hFFFF_FFFF);
        push("ro_in", 32'h1);
        push("ro_id", ID_WORD);
        push("irq_en_clip", 32'hFF);
        rd(3, obs);
        e = sb.pop_front();
        checks++;
        if (obs !== e.val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
        end
        rd(7, obs);
        e = sb.pop_front();
        checks++;
        if (obs !== e.val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
        end
        rd(6, obs);
        e = sb.pop_front();
        checks++;
        if (obs !== e.val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
        end
        wr(6, 32'h0);
        wr(5, 32'hFF);
    endtask

    task automatic test_back_to_back();
        logic [31:0] obs;
        exp_t e;
        i_pins[2] = 1'b1;
        step(DB_T - 1);
        // The W1C write lands on the same edge as the rising event.
        push("collide_rise2", 32'h4);
        push("rise2_cleared", 32'h0);
        wr(4, 32'h4);
        rd(4, obs);
        e = sb.pop_front();
        checks++;
        if (obs !== e.val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
        end
        wr(4, 32'h4);
        rd(4, obs);
        e = sb.pop_front();
        checks++;
        if (obs !== e.val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] obs;
        exp_t e;
        i_pins[3] = 1'b1;
        push("mid_no_rise", 32'h0);
        push("post_rst_early", 32'h0);
        push("post_rst_rise", 32'h0D);
        push("post_rst_in", 32'h0D);
        push("post_rst_pins", 32'(OUT_RST));
        step(8);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        rd(4, obs);
        e = sb.pop_front();
        checks++;
        if (obs !== e.val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
        end
        step(DB_T - 1);
        rd(4, obs);
        e = sb.pop_front();
        checks++;
        if (obs !== e.val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
        end
        step(1);
        rd(4, obs);
        e = sb.pop_front();
        checks++;
        if (obs !== e.val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
        end
        rd(3, obs);
        e = sb.pop_front();
        checks++;
        if (obs !== e.val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, obs, e.val);
        end
        e = sb.pop_front();
        checks++;
        if (32'(o_pins) !== e.val) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", e.name, o_pins, e.val);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        i_rreg  = 3'd0;
        i_wreg  = 3'd0;
        i_wdata = '0;
        i_wr    = 1'b0;
        i_rd    = 1'b0;
        i_pins  = '0;
        test_reset();
        test_debounce();
        test_out();
        test_irq();
        test_back_to_back();
        test_reset_mid();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
